uart_hex_to_ps2: RTL
====================

Name: uart_hex_to_ps2

Overview:
- Command path from the host UART to the PS/2 device: consumes ASCII hex characters from the UART receive FIFO, assembles them into one byte, and issues that byte to the PS/2 transmitter (ps2_rxtx wr_ps2/din).
- Sits between uart (r_data/rx_empty/rd_uart) and ps2_rxtx (wr_ps2/din/tx_done_tick).
- Replaces the switch-plus-button command entry with typed commands, e.g. "F4 " sends 0xF4 (enable data reporting).

Parameters:
- TIMEOUT_CYCLES, 2_000_000, clk cycles to wait for tx_done_tick after wr_ps2 before abandoning the send (20 ms at 100 MHz).
- CW, 21, timeout counter width; must satisfy 2^CW > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- rx_empty  in  1  UART receive FIFO empty flag.
- r_data  in  8  UART FIFO head character; valid whenever rx_empty=0 (first-word fall-through).
- rd_uart  out  1  one-cycle pop of the UART FIFO; asserted in the same cycle the character is consumed.
- tx_done_tick  in  1  one-cycle pulse from ps2_rxtx when the byte has gone out.
- wr_ps2  out  1  one-cycle request to ps2_rxtx.
- din  out  8  byte to transmit; stable from the wr_ps2 cycle until completion or timeout.
- busy  out  1  high in SEND and WAIT.
- err_tick  out  1  one-cycle pulse on a parse error or timeout.

Behaviour:
- Reset (synchronous, active-high) is sampled every clock and overrides everything, including mid-send. State goes to IDLE. rd_uart=0, wr_ps2=0, din=0x00, busy=0, err_tick=0, nibble registers=0, timeout counter=0.
- Character classes:
  - hex: 0x30-0x39 maps to 0-9; 0x41-0x46 and 0x61-0x66 map to A-F.
  - terminator: 0x20 (space) or 0x0D (CR).
  - anything else is invalid.
- rd_uart = (state is IDLE, HI or LO) AND rx_empty=0. Exactly one character is consumed per cycle. In SEND and WAIT, rd_uart is held 0 and characters stay queued in the FIFO.
- IDLE:
  - hex: store nibble as hi, go to HI.
  - terminator: discard, stay in IDLE, no error.
  - invalid: pulse err_tick, stay in IDLE.
- HI:
  - hex: store as lo, go to LO.
  - terminator: byte = {4'h0, hi}, go to SEND.
  - invalid: pulse err_tick, discard the partial byte, go to IDLE.
- LO:
  - terminator: byte = {hi, lo}, go to SEND.
  - hex (third digit) or invalid: pulse err_tick, discard, go to IDLE.
- SEND (one cycle): din <= byte (registered), wr_ps2=1, clear the timeout counter, go to WAIT.
  - Latency: terminator consumed in cycle N gives wr_ps2=1 in cycle N+1, with din valid in the same cycle.
- WAIT: counter increments each cycle.
  - tx_done_tick=1: go to IDLE with no error.
  - counter reaches TIMEOUT_CYCLES-1 with no tx_done_tick: pulse err_tick, go to IDLE.
  - tx_done_tick in the same cycle as expiry: counts as success, no err_tick.
- tx_done_tick outside WAIT, including in the SEND cycle, is ignored.
- din holds its last sent value in IDLE and is only updated in SEND.
- busy = (state==SEND) OR (state==WAIT).
- err_tick is never high in two consecutive cycles from a single event. wr_ps2 is high for exactly one cycle per accepted command.

Test Plan:
- FIFO delivers "F","4"," " on consecutive cycles -> three rd_uart pulses; wr_ps2 for 1 cycle the cycle after the space; din=0xF4; busy=1 until tx_done_tick; no err_tick.
- Lowercase "f","f",CR -> din=0xFF sent. Then "A"," " -> din=0x0A sent (single-digit rule).
- "F","G"," " -> err_tick on the "G" cycle; space ignored in IDLE; no wr_ps2. Then "1","2","3"," " -> err_tick on the "3"; no send.
- "E","D"," " with a second command "F","4"," " queued in the FIFO -> rd_uart=0 throughout WAIT. After tx_done_tick, the next three characters are popped and 0xF4 is sent.
- With TIMEOUT_CYCLES=16 and "F","F"," " but no tx_done_tick -> err_tick exactly 16 cycles after wr_ps2; returns to IDLE and accepts new input. Repeat with tx_done_tick on the expiry cycle -> no err_tick.
- Assert reset for 1 cycle during WAIT and, separately, after "F" in HI -> next cycle all outputs at reset values and state IDLE. A following "3","0"," " sends 0x30 (no stale hi nibble).

Source files
------------

// File: rtl/uart_hex_to_ps2.sv
// uart_hex_to_ps2
// Turns typed ASCII hex commands from the host UART into single-byte PS/2
// commands. One or two hex digits followed by a space or CR make one byte,
// e.g. "F4 " sends 0xF4. The byte is handed to ps2_rxtx and the block waits
// for its completion tick, giving up after TIMEOUT_CYCLES.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   rx_empty     UART receive FIFO empty flag
//   r_data       UART FIFO head character (first-word fall-through)
//   rd_uart      one-cycle FIFO pop, same cycle the character is consumed
//   tx_done_tick completion pulse from ps2_rxtx
//   wr_ps2       one-cycle transmit request to ps2_rxtx
//   din          byte to transmit, held until the next command is sent
//   busy         high while a byte is being sent or awaited
//   err_tick     one-cycle pulse on a parse error or a send timeout
module uart_hex_to_ps2 #(
   parameter int TIMEOUT_CYCLES = 2_000_000,
   parameter int CW             = 21
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_empty,
   input  logic [7:0] r_data,
   output logic       rd_uart,
   input  logic       tx_done_tick,
   output logic       wr_ps2,
   output logic [7:0] din,
   output logic       busy,
   output logic       err_tick
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HI,
      S_LO,
      S_SEND,
      S_WAIT
   } state_t;

   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   state_t        state_q, state_d;
   logic [3:0]    hi_q, hi_d;
   logic [3:0]    lo_q, lo_d;
   logic [7:0]    din_q, din_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Returns {is_hex, is_term, nibble} for one ASCII character.
   function automatic logic [5:0] classify(input logic [7:0] c);
      logic       is_hex;
      logic       is_term;
      logic [3:0] nib;
      is_hex  = 1'b0;
      is_term = 1'b0;
      nib     = 4'h0;
      if (c >= 8'h30 && c <= 8'h39) begin
         is_hex = 1'b1;
         nib    = c[3:0];
      end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
         // 'A'/'a' have low nibble 1, so adding 9 yields 10..15
         is_hex = 1'b1;
         nib    = c[3:0] + 4'd9;
      end else if (c == 8'h20 || c == 8'h0D) begin
         is_term = 1'b1;
      end
      return {is_hex, is_term, nib};
   endfunction

   logic [5:0] cls;
   logic       c_hex;
   logic       c_term;
   logic [3:0] c_nib;

   assign cls    = classify(r_data);
   assign c_hex  = cls[5];
   assign c_term = cls[4];
   assign c_nib  = cls[3:0];

   always_comb begin
      state_d  = state_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      din_d    = din_q;
      cnt_d    = cnt_q;
      rd_uart  = 1'b0;
      wr_ps2   = 1'b0;
      err_tick = 1'b0;
      busy     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (!rx_empty) begin
               rd_uart = 1'b1;
               if (c_hex) begin
                  hi_d    = c_nib;
                  state_d = S_HI;
               end else if (!c_term) begin
                  err_tick = 1'b1;
               end
            end
         end
         S_HI: begin
            if (!rx_empty) begin
               rd_uart = 1'b1;
               if (c_hex) begin
                  lo_d    = c_nib;
                  state_d = S_LO;
               end else if (c_term) begin
                  // Loaded on entry to SEND so din is already valid with wr_ps2
                  din_d   = {4'h0, hi_q};
                  state_d = S_SEND;
               end else begin
                  err_tick = 1'b1;
                  state_d  = S_IDLE;
               end
            end
         end
         S_LO: begin
            if (!rx_empty) begin
               rd_uart = 1'b1;
               if (c_term) begin
                  din_d   = {hi_q, lo_q};
                  state_d = S_SEND;
               end else begin
                  err_tick = 1'b1;
                  state_d  = S_IDLE;
               end
            end
         end
         S_SEND: begin
            wr_ps2  = 1'b1;
            busy    = 1'b1;
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            busy  = 1'b1;
            cnt_d = cnt_q + CW'(1);
            // Completion wins over a timeout that expires in the same cycle
            if (tx_done_tick) begin
               state_d = S_IDLE;
            end else if (cnt_q == CNT_LAST) begin
               err_tick = 1'b1;
               state_d  = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Reset also silences the strobes in the reset cycle itself, so no
      // character is popped and no request escapes while reset is high.
      if (reset) begin
         rd_uart  = 1'b0;
         wr_ps2   = 1'b0;
         err_tick = 1'b0;
         busy     = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         hi_q    <= 4'h0;
         lo_q    <= 4'h0;
         din_q   <= 8'h00;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         din_q   <= din_d;
         cnt_q   <= cnt_d;
      end
   end

   assign din = din_q;

endmodule
